// File: rtl/if_stage.sv
// Instruction-fetch stage.
// Owns the program counter, issues one fetch at a time to a variable-latency
// instruction memory over a req/ack handshake, and presents
// {PC+4, Instruction, valid} to the IF/ID register. A one-entry skid buffer
// keeps a word that returns while the pipeline is frozen. A branch that
// arrives while a request is outstanding drains that request and discards
// its data before fetching the target.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction,
    output logic        valid
);

    // FETCH: request at pc outstanding or about to be issued.
    // HOLD : a word is parked in the skid buffer, no request issued.
    // DRAIN: an abandoned request is still in flight; its data is discarded.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_reg,      state_next;
    logic [31:0] pc_reg,         pc_next;
    logic [31:0] drain_addr_reg, drain_addr_next;
    logic [31:0] skid_instr_reg, skid_instr_next;
    logic [31:0] skid_pc_reg,    skid_pc_next;
    logic        valid_reg,      valid_next;
    logic [31:0] instr_reg,      instr_next;
    logic [31:0] pc_out_reg,     pc_out_next;

    logic [31:0] branch_target;
    logic [31:0] pc_plus4;

    // Word-aligned redirect target and sequential successor (modulo 2^32).
    assign branch_target = branch_addr & 32'hFFFF_FFFC;
    assign pc_plus4      = pc_reg + 32'd4;

    // The request is withdrawn during reset so the memory sees it cancelled.
    assign imem_req  = ((state_reg == FETCH) || (state_reg == DRAIN)) && !rst;
    assign imem_addr = (state_reg == DRAIN) ? drain_addr_reg : pc_reg;

    assign valid       = valid_reg;
    assign Instruction = instr_reg;
    assign PC_out      = pc_out_reg;

    // State, PC, skid buffer and output register; reset is asynchronous.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= FETCH;
            pc_reg         <= RESET_PC;
            drain_addr_reg <= 32'h0;
            skid_instr_reg <= 32'h0;
            skid_pc_reg    <= 32'h0;
            valid_reg      <= 1'b0;
            instr_reg      <= 32'h0;
            pc_out_reg     <= 32'h0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            drain_addr_reg <= drain_addr_next;
            skid_instr_reg <= skid_instr_next;
            skid_pc_reg    <= skid_pc_next;
            valid_reg      <= valid_next;
            instr_reg      <= instr_next;
            pc_out_reg     <= pc_out_next;
        end
    end

    // Next-state, PC, skid and output-register update. Everything holds by
    // default, which is what a frozen cycle without a branch needs.
    always_comb begin
        state_next      = state_reg;
        pc_next         = pc_reg;
        drain_addr_next = drain_addr_reg;
        skid_instr_next = skid_instr_reg;
        skid_pc_next    = skid_pc_reg;
        valid_next      = valid_reg;
        instr_next      = instr_reg;
        pc_out_next     = pc_out_reg;

        case (state_reg)
            FETCH: begin
                if (branch_taken) begin
                    // Branch beats freeze; any word acked now is dropped.
                    valid_next      = 1'b0;
                    skid_instr_next = 32'h0;
                    skid_pc_next    = 32'h0;
                    pc_next         = branch_target;
                    if (!imem_ack) begin
                        // Request still in flight: keep its address on the
                        // bus until the memory answers.
                        drain_addr_next = pc_reg;
                        state_next      = DRAIN;
                    end
                end else if (imem_ack) begin
                    pc_next = pc_plus4;
                    if (!freeze) begin
                        valid_next  = 1'b1;
                        instr_next  = imem_rdata;
                        pc_out_next = pc_plus4;
                    end else begin
                        // Decode is stalled; park the word until it frees up.
                        skid_instr_next = imem_rdata;
                        skid_pc_next    = pc_plus4;
                        state_next      = HOLD;
                    end
                end else if (!freeze) begin
                    // Memory wait state with the pipeline moving: bubble.
                    valid_next = 1'b0;
                end
            end

            HOLD: begin
                if (branch_taken) begin
                    valid_next      = 1'b0;
                    skid_instr_next = 32'h0;
                    skid_pc_next    = 32'h0;
                    pc_next         = branch_target;
                    state_next      = FETCH;
                end else if (!freeze) begin
                    valid_next      = 1'b1;
                    instr_next      = skid_instr_reg;
                    pc_out_next     = skid_pc_reg;
                    skid_instr_next = 32'h0;
                    skid_pc_next    = 32'h0;
                    state_next      = FETCH;
                end
            end

            DRAIN: begin
                // No new data arrives while draining; the consumer sees
                // bubbles whenever it is not frozen.
                if (branch_taken || !freeze) begin
                    valid_next = 1'b0;
                end
                if (branch_taken) begin
                    // Newer redirect replaces the pending target.
                    pc_next         = branch_target;
                    skid_instr_next = 32'h0;
                    skid_pc_next    = 32'h0;
                end
                if (imem_ack) begin
                    // Abandoned word arrives and is thrown away.
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_if_stage.sv
// Randomized self-checking bench for if_stage. A variable-latency memory
// model answers fetches with addr ^ 0xA5A5_0000; a transaction-level model
// (expected PC, queue of parked words, outstanding stale request) predicts
// the fetch bus and the IF/ID outputs every cycle.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam int          NCYC     = 3000;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] PC_out;
    logic [31:0] Instruction;
    logic        valid;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .branch_taken(branch_taken),
        .branch_addr (branch_addr),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .PC_out      (PC_out),
        .Instruction (Instruction),
        .valid       (valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned n_checks;
    int unsigned n_fail;
    int          cyc;

    // Reference model state
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } word_t;

    word_t       skid_q[$];
    logic [31:0] m_pc;
    bit          stale;
    logic [31:0] stale_addr;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_pcout;

    // Memory model state
    bit          mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        skid_q.delete();
        m_pc     = RESET_PC;
        stale    = 1'b0;
        stale_addr = 32'h0;
        m_valid  = 1'b0;
        m_instr  = 32'h0;
        m_pcout  = 32'h0;
        mem_busy = 1'b0;
        mem_cnt  = 0;
        mem_addr = 32'h0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_valid"}, {31'h0, valid}, 32'h0);
        check_eq({tag, "_instr"}, Instruction, 32'h0);
        check_eq({tag, "_pcout"}, PC_out, 32'h0);
        check_eq({tag, "_req"}, {31'h0, imem_req}, 32'h0);
    endtask

    function automatic int pick_lat();
        int r;
        if (cyc < 150) return 0;
        if (cyc < 300) return 2;
        r = $urandom_range(0, 9);
        if (r < 4) return 0;
        if (r < 7) return 1;
        if (r < 9) return 2;
        return 3;
    endfunction

    // Apply one clock edge of the fetch rules to the model.
    task automatic model_update(input bit f, input bit b, input logic [31:0] t, input bit a);
        bit    holding;
        word_t w;
        holding = (skid_q.size() != 0);
        if (b) begin
            m_valid = 1'b0;
            if (stale) begin
                if (a) stale = 1'b0;
            end else if (!holding && !a) begin
                stale      = 1'b1;
                stale_addr = m_pc;
            end
            skid_q.delete();
            m_pc = t & 32'hFFFF_FFFC;
        end else if (stale) begin
            if (a) stale = 1'b0;
            if (!f) m_valid = 1'b0;
        end else if (holding) begin
            if (!f) begin
                w       = skid_q.pop_front();
                m_valid = 1'b1;
                m_instr = w.instr;
                m_pcout = w.pc;
                $display("[%0d] present pc_out=%h instr=%h (from skid)", cyc, m_pcout, m_instr);
            end
        end else if (a) begin
            if (!f) begin
                m_valid = 1'b1;
                m_instr = m_pc ^ KEY;
                m_pcout = m_pc + 32'd4;
                $display("[%0d] present pc_out=%h instr=%h", cyc, m_pcout, m_instr);
            end else begin
                w.instr = m_pc ^ KEY;
                w.pc    = m_pc + 32'd4;
                skid_q.push_back(w);
            end
            m_pc = m_pc + 32'd4;
        end else if (!f) begin
            m_valid = 1'b0;
        end
    endtask

    // One cycle: compare DUT against model, drive inputs and memory, advance model.
    task automatic step();
        bit          f;
        bit          b;
        logic [31:0] t;
        int          r;

        check_eq("valid", {31'h0, valid}, {31'h0, m_valid});
        if (m_valid) begin
            check_eq("instr", Instruction, m_instr);
            check_eq("pc_out", PC_out, m_pcout);
        end
        check_eq("imem_req", {31'h0, imem_req}, {31'h0, (skid_q.size() == 0)});
        if (skid_q.size() == 0)
            check_eq("imem_addr", imem_addr, stale ? stale_addr : m_pc);

        f = 1'b0;
        b = 1'b0;
        t = 32'h0;
        if (cyc >= 300) begin
            f = ($urandom_range(0, 3) == 0);
            b = ($urandom_range(0, 11) == 0);
            r = $urandom_range(0, 3);
            case (r)
                0: t = 32'hFFFF_FFFC;
                1: t = 32'h0000_0403;
                default: t = $urandom;
            endcase
        end
        freeze       = f;
        branch_taken = b;
        branch_addr  = t;

        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        if (imem_req) begin
            if (!mem_busy) begin
                mem_busy = 1'b1;
                mem_addr = imem_addr;
                mem_cnt  = pick_lat();
            end else begin
                check_eq("addr_stable", imem_addr, mem_addr);
            end
            if (mem_cnt == 0) begin
                imem_ack   = 1'b1;
                imem_rdata = mem_addr ^ KEY;
                mem_busy   = 1'b0;
            end else begin
                mem_cnt--;
            end
        end else if (mem_busy) begin
            check_eq("req_held", {31'h0, imem_req}, 32'h1);
        end

        model_update(f, b, t, imem_ack);
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        cyc          = 0;
        rst          = 1'b1;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        branch_addr  = 32'h0;
        imem_ack     = 1'b0;
        imem_rdata   = 32'h0;
        model_reset();

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        #1;

        for (cyc = 0; cyc < NCYC; cyc++) begin
            if (cyc == 2000) begin
                // Asynchronous reset in the middle of traffic.
                rst          = 1'b1;
                freeze       = 1'b0;
                branch_taken = 1'b0;
                imem_ack     = 1'b0;
                #1;
                check_reset_outputs("midreset");
                model_reset();
                @(negedge clk);
                rst = 1'b0;
                #1;
            end
            step();
            @(negedge clk);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
